// File: rtl/ex_wb_seq_pkg.sv
// Shared types and constants for the execute-to-writeback stage.
package ex_wb_seq_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned RA_W_DEFAULT   = 4;

  // ALU flag vector bit positions
  localparam int unsigned FLAG_SAT = 4;
  localparam int unsigned FLAG_N   = 3;
  localparam int unsigned FLAG_Z   = 2;
  localparam int unsigned FLAG_C   = 1;
  localparam int unsigned FLAG_V   = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR1  = 2'd1,
    S_HI   = 2'd2
  } state_e;

endpackage

// File: rtl/ex_wb_seq_flag_reg.sv
// Architectural NZCV flags and sticky Q saturation flag.
module ex_wb_seq_flag_reg
  import ex_wb_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       accept_i,
  input  logic       cond_ex_i,
  input  logic [1:0] flag_write_i,
  input  logic [4:0] alu_flags_i,
  input  logic       clear_q_i,
  output logic [3:0] nzcv_o,
  output logic       q_flag_o
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       q_q, q_d;
  logic       upd;

  assign upd = accept_i & cond_ex_i;

  always_comb begin
    nzcv_d = nzcv_q;
    q_d    = q_q;
    if (upd && flag_write_i[1]) begin
      nzcv_d[3] = alu_flags_i[FLAG_N];
      nzcv_d[2] = alu_flags_i[FLAG_Z];
    end
    if (upd && flag_write_i[0]) begin
      nzcv_d[1] = alu_flags_i[FLAG_C];
      nzcv_d[0] = alu_flags_i[FLAG_V];
    end
    // Set takes priority over a simultaneous clear.
    if (upd && alu_flags_i[FLAG_SAT]) begin
      q_d = 1'b1;
    end else if (clear_q_i) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nzcv_q <= 4'b0000;
      q_q    <= 1'b0;
    end else begin
      nzcv_q <= nzcv_d;
      q_q    <= q_d;
    end
  end

  assign nzcv_o   = nzcv_q;
  assign q_flag_o = q_q;

endmodule

// File: rtl/ex_wb_seq.sv
// Execute-to-writeback stage: registers ALU results and sequences single-port
// register-file writes, splitting long results into Lo then Hi writes.
module ex_wb_seq
  import ex_wb_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned RA_W   = RA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              cond_ex,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] result2,
  input  logic [4:0]        alu_flags,
  input  logic              reg_write,
  input  logic              long_op,
  input  logic [RA_W-1:0]   rd_lo,
  input  logic [RA_W-1:0]   rd_hi,
  input  logic [1:0]        flag_write,
  input  logic              clear_q,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [3:0]        nzcv,
  output logic              q_flag
);

  state_e            state_q, state_d;
  logic              long_q, long_d;
  logic [RA_W-1:0]   rd_hi_q, rd_hi_d;
  logic [DATA_W-1:0] res2_q, res2_d;
  logic              rf_we_q, rf_we_d;
  logic [RA_W-1:0]   rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic              accept;
  logic              take;

  assign ready_out = !((state_q == S_WR1) && long_q);
  assign accept    = valid_in & ready_out;
  assign take      = accept & cond_ex & reg_write;

  // The Lo word goes straight into the rf_* registers on accept; only the
  // Hi half needs to be held for the following cycle.
  always_comb begin
    state_d = S_IDLE;
    long_d  = long_q;
    rd_hi_d = rd_hi_q;
    res2_d  = res2_q;
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if ((state_q == S_WR1) && long_q) begin
      state_d = S_HI;
      rf_we_d = 1'b1;
      rf_wa_d = rd_hi_q;
      rf_wd_d = res2_q;
    end else if (take) begin
      state_d = S_WR1;
      long_d  = long_op;
      rd_hi_d = rd_hi;
      res2_d  = result2;
      rf_we_d = 1'b1;
      rf_wa_d = rd_lo;
      rf_wd_d = result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      long_q  <= 1'b0;
      rd_hi_q <= '0;
      res2_q  <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
      rd_hi_q <= rd_hi_d;
      res2_q  <= res2_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  ex_wb_seq_flag_reg u_flag_reg (
    .clk_i        (clk),
    .rst_ni       (reset),
    .accept_i     (accept),
    .cond_ex_i    (cond_ex),
    .flag_write_i (flag_write),
    .alu_flags_i  (alu_flags),
    .clear_q_i    (clear_q),
    .nzcv_o       (nzcv),
    .q_flag_o     (q_flag)
  );

endmodule
